// File: rtl/mem_load_align.sv
// Load-return stage: tracks BRAM reads through the fixed read latency, restores lane order,
// extends the result and buffers it in a 2-entry skid. Optional misalign trap: MEM_MISALIGN_TRAP_EN.
module mem_load_align #(
    parameter logic [1:0]  MEM_DISABLE    = 2'b00,
    parameter logic [1:0]  MEM_READ_SEXT  = 2'b01,
    parameter logic [1:0]  MEM_READ_ZEXT  = 2'b10,
    parameter logic [1:0]  MEM_WRITE      = 2'b11,
    parameter logic [1:0]  BYTE           = 2'b00,
    parameter logic [1:0]  HALFWORD       = 2'b01,
    parameter logic [1:0]  WORD           = 2'b10,
    parameter logic [31:0] READ_REG_INPUT = 32'h0200_0000,
    parameter int unsigned READ_LATENCY   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [1:0]  memOp,
    input  logic [1:0]  memSize,
    input  logic [31:0] doutB,
    input  logic [31:0] edgeIn,
    input  logic        stall,
    output logic [31:0] loadData,
    output logic        loadValid,
    output logic        overflow,
    output logic        misalign
);

    typedef struct packed {
        logic       valid;
        logic       sext;
        logic [1:0] size;
        logic [1:0] lane;
        logic       isMmio;
        logic       bad;
    } sideBand_t;

    sideBand_t   reqBand;
    sideBand_t   arrBand;
    sideBand_t   pipe [READ_LATENCY];

    logic [31:0] edgeSync1;
    logic [31:0] edgeSync2;

    logic [15:0] halfVal;
    logic [7:0]  byteVal;
    logic [31:0] fmtData;
    logic        fmtMisalign;

    logic [31:0] skidData [2];
    logic        skidMis  [2];
    logic [1:0]  skidCount;

    always_comb begin
        reqBand        = '0;
        reqBand.valid  = (memOp == MEM_READ_SEXT) || (memOp == MEM_READ_ZEXT);
        reqBand.sext   = (memOp == MEM_READ_SEXT);
        reqBand.size   = memSize;
        reqBand.lane   = addr[1:0];
        reqBand.isMmio = (addr == READ_REG_INPUT);
        reqBand.bad    = !reqBand.isMmio &&
                         ((memSize == HALFWORD && addr[0]) ||
                          (memSize == WORD && addr[1:0] != 2'b00) ||
                          (memSize == 2'b11));
    end

    // BRAM cannot stall, so the sideband pipe advances unconditionally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= reqBand;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign arrBand = pipe[READ_LATENCY-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edgeSync1 <= '0;
            edgeSync2 <= '0;
        end else begin
            edgeSync1 <= edgeIn;
            edgeSync2 <= edgeSync1;
        end
    end

    // Store path writes byte-swapped; undo that before lane selection
    always_comb begin
        halfVal     = arrBand.lane[1] ? {doutB[23:16], doutB[31:24]}
                                      : {doutB[7:0], doutB[15:8]};
        byteVal     = '0;
        fmtData     = '0;
        fmtMisalign = 1'b0;
        case (arrBand.lane)
            2'd0:    byteVal = doutB[7:0];
            2'd1:    byteVal = doutB[15:8];
            2'd2:    byteVal = doutB[23:16];
            default: byteVal = doutB[31:24];
        endcase
        if (arrBand.isMmio) begin
            fmtData = edgeSync2;
        end else if (arrBand.bad) begin
`ifdef MEM_MISALIGN_TRAP_EN
            fmtData     = '0;
            fmtMisalign = 1'b1;
`else
            fmtData     = 32'hCAFE_BABE;
`endif
        end else if (arrBand.size == WORD) begin
            fmtData = {doutB[7:0], doutB[15:8], doutB[23:16], doutB[31:24]};
        end else if (arrBand.size == HALFWORD) begin
            fmtData = {{16{arrBand.sext & halfVal[15]}}, halfVal};
        end else begin
            fmtData = {{24{arrBand.sext & byteVal[7]}}, byteVal};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loadData  <= '0;
            loadValid <= 1'b0;
            overflow  <= 1'b0;
            misalign  <= 1'b0;
            skidCount <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                skidData[i] <= '0;
                skidMis[i]  <= 1'b0;
            end
        end else if (!stall && skidCount != 2'd0) begin
            loadData  <= skidData[0];
            misalign  <= skidMis[0];
            loadValid <= 1'b1;
            // Pop shifts the tail to the head; a same-cycle arrival refills behind it
            if (skidCount == 2'd2) begin
                skidData[0] <= skidData[1];
                skidMis[0]  <= skidMis[1];
                if (arrBand.valid) begin
                    skidData[1] <= fmtData;
                    skidMis[1]  <= fmtMisalign;
                end else begin
                    skidCount <= 2'd1;
                end
            end else if (arrBand.valid) begin
                skidData[0] <= fmtData;
                skidMis[0]  <= fmtMisalign;
            end else begin
                skidCount <= 2'd0;
            end
        end else if (!stall && arrBand.valid) begin
            loadData  <= fmtData;
            misalign  <= fmtMisalign;
            loadValid <= 1'b1;
        end else begin
            loadValid <= 1'b0;
            if (arrBand.valid) begin
                if (skidCount == 2'd2) begin
                    overflow <= 1'b1;
                end else if (skidCount == 2'd1) begin
                    skidData[1] <= fmtData;
                    skidMis[1]  <= fmtMisalign;
                    skidCount   <= 2'd2;
                end else begin
                    skidData[0] <= fmtData;
                    skidMis[0]  <= fmtMisalign;
                    skidCount   <= 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_load_align.sv
// Directed self-checking bench for mem_load_align: one instance at READ_LATENCY=1,
// one at READ_LATENCY=2 for the skid/overflow sequence.
module tb_mem_load_align;

    localparam logic [1:0] DIS  = 2'b00;
    localparam logic [1:0] SEXT = 2'b01;
    localparam logic [1:0] ZEXT = 2'b10;
    localparam logic [1:0] SB   = 2'b00;
    localparam logic [1:0] SH   = 2'b01;
    localparam logic [1:0] SW   = 2'b10;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam logic [31:0] BAD_DATA = 32'h0000_0000;
    localparam logic        BAD_MIS  = 1'b1;
`else
    localparam logic [31:0] BAD_DATA = 32'hCAFE_BABE;
    localparam logic        BAD_MIS  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] edgeIn = 32'h1234_5678;

    logic [31:0] addr1 = '0, doutB1 = '0;
    logic [1:0]  memOp1 = DIS, memSize1 = SW;
    logic        stall1 = 1'b0;
    logic [31:0] loadData1;
    logic        loadValid1, overflow1, misalign1;

    logic [31:0] addr2 = '0, doutB2 = '0;
    logic [1:0]  memOp2 = DIS, memSize2 = SW;
    logic        stall2 = 1'b0;
    logic [31:0] loadData2;
    logic        loadValid2, overflow2, misalign2;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mem_load_align u1 (
        .clk(clk), .reset(reset), .addr(addr1), .memOp(memOp1), .memSize(memSize1),
        .doutB(doutB1), .edgeIn(edgeIn), .stall(stall1), .loadData(loadData1),
        .loadValid(loadValid1), .overflow(overflow1), .misalign(misalign1)
    );

    mem_load_align #(.READ_LATENCY(2)) u2 (
        .clk(clk), .reset(reset), .addr(addr2), .memOp(memOp2), .memSize(memSize2),
        .doutB(doutB2), .edgeIn(edgeIn), .stall(stall2), .loadData(loadData2),
        .loadValid(loadValid2), .overflow(overflow2), .misalign(misalign2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Single load on the latency-1 instance: request, data one cycle later, result the next
    task automatic load1(input string tag, input logic [1:0] op, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] expData, input logic expMis);
        addr1 = a; memOp1 = op; memSize1 = sz;
        tick();
        memOp1 = DIS; addr1 = '0; doutB1 = d;
        check({tag, "_early"}, {31'd0, loadValid1}, 32'd0);
        tick();
        check({tag, "_valid"}, {31'd0, loadValid1}, 32'd1);
        check({tag, "_data"}, loadData1, expData);
        check({tag, "_mis"}, {31'd0, misalign1}, {31'd0, expMis});
    endtask

    initial begin
        tick();
        tick();
        check("rst_data", loadData1, 32'd0);
        check("rst_valid", {31'd0, loadValid1}, 32'd0);
        check("rst_ovf", {31'd0, overflow1}, 32'd0);
        check("rst_mis", {31'd0, misalign1}, 32'd0);
        reset = 1'b0;
        tick();
        tick();

        load1("word", ZEXT, SW, 32'h0, 32'h4433_2211, 32'h1122_3344, 1'b0);
        tick();
        check("word_pulse", {31'd0, loadValid1}, 32'd0);
        check("word_hold", loadData1, 32'h1122_3344);

        load1("byte_s", SEXT, SB, 32'h1, 32'h0000_8000, 32'hFFFF_FF80, 1'b0);
        load1("byte_z", ZEXT, SB, 32'h1, 32'h0000_8000, 32'h0000_0080, 1'b0);
        load1("byte3_s", SEXT, SB, 32'h3, 32'h7F00_0000, 32'h0000_007F, 1'b0);
        load1("half_z", ZEXT, SH, 32'h2, 32'hCDAB_0000, 32'h0000_ABCD, 1'b0);
        load1("half_s", SEXT, SH, 32'h2, 32'hCDAB_0000, 32'hFFFF_ABCD, 1'b0);
        load1("half0_s", SEXT, SH, 32'h0, 32'h0000_3412, 32'h0000_1234, 1'b0);
        load1("half_mis", SEXT, SH, 32'h1, 32'h1111_1111, BAD_DATA, BAD_MIS);
        load1("word_mis", ZEXT, SW, 32'h2, 32'h2222_2222, BAD_DATA, BAD_MIS);
        load1("size3", ZEXT, 2'b11, 32'h0, 32'h3333_3333, BAD_DATA, BAD_MIS);
        load1("mmio", SEXT, SW, 32'h0200_0000, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);

        // Latency-2 instance: A and B back to back, stalled across both arrivals
        addr2 = '0; memOp2 = ZEXT; memSize2 = SW;
        tick();
        tick();
        memOp2 = DIS; doutB2 = 32'h0000_000A; stall2 = 1'b1;
        check("stl_v0", {31'd0, loadValid2}, 32'd0);
        tick();
        doutB2 = 32'h0000_000B;
        check("stl_v1", {31'd0, loadValid2}, 32'd0);
        tick();
        check("stl_v2", {31'd0, loadValid2}, 32'd0);
        tick();
        check("stl_v3", {31'd0, loadValid2}, 32'd0);
        check("stl_ovf", {31'd0, overflow2}, 32'd0);
        stall2 = 1'b0;
        tick();
        check("popA_v", {31'd0, loadValid2}, 32'd1);
        check("popA_d", loadData2, 32'h0A00_0000);
        tick();
        check("popB_v", {31'd0, loadValid2}, 32'd1);
        check("popB_d", loadData2, 32'h0B00_0000);
        tick();
        check("drain_v", {31'd0, loadValid2}, 32'd0);
        check("drain_ovf", {31'd0, overflow2}, 32'd0);

        // Three arrivals while stalled: the third is discarded and sets overflow
        stall2 = 1'b1; memOp2 = ZEXT;
        tick();
        tick();
        doutB2 = 32'h0000_000C;
        tick();
        memOp2 = DIS; doutB2 = 32'h0000_000D;
        check("ovf_pre0", {31'd0, overflow2}, 32'd0);
        tick();
        doutB2 = 32'h0000_000E;
        check("ovf_pre1", {31'd0, overflow2}, 32'd0);
        tick();
        check("ovf_set", {31'd0, overflow2}, 32'd1);
        check("ovf_nov", {31'd0, loadValid2}, 32'd0);
        stall2 = 1'b0;
        tick();
        check("popC_d", loadData2, 32'h0C00_0000);
        tick();
        check("popD_v", {31'd0, loadValid2}, 32'd1);
        check("popD_d", loadData2, 32'h0D00_0000);
        tick();
        check("popE_none", {31'd0, loadValid2}, 32'd0);
        check("ovf_sticky", {31'd0, overflow2}, 32'd1);

        // Reset with a load in flight on the latency-1 instance
        addr1 = 32'h0; memOp1 = ZEXT; memSize1 = SW;
        tick();
        memOp1 = DIS; doutB1 = 32'h5555_5555;
        reset = 1'b1;
        #1;
        check("arst_data", loadData1, 32'd0);
        check("arst_valid", {31'd0, loadValid1}, 32'd0);
        check("arst_ovf2", {31'd0, overflow2}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("arst_drop0", {31'd0, loadValid1}, 32'd0);
        tick();
        check("arst_drop1", {31'd0, loadValid1}, 32'd0);
        check("arst_hold", loadData1, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
